jtag_ir_unit: RTL
=================

// Module: jtag_ir_unit
// PURPOSE
//  Parametrised JTAG instruction register: capture/shift/update IR path plus registered one-hot decode.
//  Sits between the TAP controller (supplies capture/shift/update strobes) and the DR muxes/BIST engines.
//  Adds over the combinational decoder: IR_WIDTH generalisation, status capture, IDCODE, reset opcode,
//  unknown-opcode-as-BYPASS with illegal flag.
// PARAMETERS
//  IR_WIDTH   4      IR length in bits, >=4; opcodes are zero-extended to IR_WIDTH
//  RESET_OP   0      opcode loaded on reset / test-logic-reset (0 = BYPASS)
// PORTS
//  tck          in   1          test clock; all state on rising edge
//  trst_n       in   1          synchronous active-low reset
//  tlr          in   1          TAP in Test-Logic-Reset; same effect as trst_n low
//  tdi          in   1          serial data in
//  capture_ir   in   1          TAP Capture-IR strobe
//  shift_ir     in   1          TAP Shift-IR strobe
//  update_ir    in   1          TAP Update-IR strobe
//  status_in    in   IR_WIDTH-2 status bits captured into IR[IR_WIDTH-1:2]
//  ir_tdo       out  1          serial out = shift_reg[0] (combinational; falling-edge retime in TAP top)
//  ir_q         out  IR_WIDTH   active instruction register
//  bypass,sample,preload,extest,intest,runmbist,runscan,runlbist,progmbist,proglbist,idcode
//               out  1 each     registered one-hot decode of ir_q
//  illegal_op   out  1          1-cycle pulse: unknown opcode updated
// BEHAVIOUR
//  Opcodes: BYPASS 0000, SAMPLE 0001, PRELOAD 0010, EXTEST 0011, RUN_MBIST 0100, RUNSCAN 0101,
//   INTEST 0110, PROG_MBIST 0111, IDCODE 1000, PROG_LBIST 1001, RUN_LBIST 1010; all-ones also BYPASS.
//  Reset (trst_n=0 or tlr=1 at edge): shift_reg<=RESET_OP, ir_q<=RESET_OP, decode of RESET_OP
//   (default bypass=1, rest 0), illegal_op=0. Reset overrides all strobes.
//  Priority otherwise: update_ir > capture_ir > shift_ir; TAP keeps them exclusive, priority is defined anyway.
//  Capture: shift_reg <= {status_in, 2'b01} (LSBs fixed 01 per 1149.1).
//  Shift: shift_reg <= {tdi, shift_reg[IR_WIDTH-1:1]}; LSB first out ir_tdo; ir_q and decode unchanged.
//  Update: ir_q <= shift_reg; decode flags computed from shift_reg and registered at the same edge,
//   so ir_q and flags change together, 1 tck after the update edge is sampled; no other latency.
//  Idle (no strobe): all registers hold; decode outputs stable across capture/shift.
//  Unknown opcode (any code not listed, incl. upper bits nonzero for IR_WIDTH>4 except all-ones):
//   ir_q holds the raw code, bypass=1, others 0, illegal_op=1 for exactly one cycle.
//  Exactly one decode output is 1 at all times after reset (one-hot invariant).
//  Reset mid-shift: partial shift content discarded, returns to RESET_OP.
// STRUCTURE
//  Package jtag_pkg: opcode localparams (4-bit), IR_BYPASS_ALL1 rule, capture LSB constant 2'b01.
//  Sub-module jtag_ir_dec: combinational opcode -> one-hot + illegal, parametrised on IR_WIDTH;
//   instantiated once, output registered in jtag_ir_unit.
// TESTING
//  1 Reset: trst_n=0 one edge -> ir_q=0000, bypass=1, all other flags 0, ir_tdo=0.
//  2 Capture with status_in=2'b10 -> 4 shifts out on ir_tdo: 1,0,0,1 (LSB first, 1001).
//  3 Shift 0011 LSB first (tdi 1,1,0,0), update -> ir_q=0011, extest=1 next cycle; flags unchanged during shift.
//  4 Load 1111 -> bypass=1, illegal_op=0; load 1100 -> bypass=1, illegal_op pulses 1 cycle, ir_q=1100.
//  5 tlr=1 mid-shift after RUN_LBIST active -> ir_q=RESET_OP, bypass=1; capture+shift same cycle -> capture wins.
//  6 IR_WIDTH=6: shift 000100 -> runmbist=1; shift 010100 -> illegal; 111111 -> bypass; check one-hot each cycle.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG IR definitions: 4-bit opcodes, capture pattern and the decode flag bundle.
package jtag_pkg;

    localparam logic [3:0] OP_BYPASS     = 4'b0000;
    localparam logic [3:0] OP_SAMPLE     = 4'b0001;
    localparam logic [3:0] OP_PRELOAD    = 4'b0010;
    localparam logic [3:0] OP_EXTEST     = 4'b0011;
    localparam logic [3:0] OP_RUN_MBIST  = 4'b0100;
    localparam logic [3:0] OP_RUNSCAN    = 4'b0101;
    localparam logic [3:0] OP_INTEST     = 4'b0110;
    localparam logic [3:0] OP_PROG_MBIST = 4'b0111;
    localparam logic [3:0] OP_IDCODE     = 4'b1000;
    localparam logic [3:0] OP_PROG_LBIST = 4'b1001;
    localparam logic [3:0] OP_RUN_LBIST  = 4'b1010;

    // The all-ones instruction is a legal BYPASS alias at any IR width.
    localparam bit IR_BYPASS_ALL1 = 1'b1;

    // Fixed LSBs loaded during Capture-IR.
    localparam logic [1:0] CAPTURE_LSB = 2'b01;

    typedef struct packed {
        logic bypass;
        logic sample;
        logic preload;
        logic extest;
        logic intest;
        logic runmbist;
        logic runscan;
        logic runlbist;
        logic progmbist;
        logic proglbist;
        logic idcode;
    } ir_dec_t;

endpackage

// File: rtl/jtag_ir_dec.sv
// Combinational instruction decode: IR code to one-hot flags plus an illegal-opcode indication.
module jtag_ir_dec
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH = 4
) (
    input  logic [IR_WIDTH-1:0] op,
    output ir_dec_t             dec,
    output logic                illegal
);

    always_comb begin
        dec     = '0;
        illegal = 1'b0;
        if (IR_BYPASS_ALL1 && (op == '1)) begin
            dec.bypass = 1'b1;
        end else begin
            // Opcodes are zero-extended, so nonzero upper bits fall through to default.
            case (op)
                IR_WIDTH'(OP_BYPASS):     dec.bypass    = 1'b1;
                IR_WIDTH'(OP_SAMPLE):     dec.sample    = 1'b1;
                IR_WIDTH'(OP_PRELOAD):    dec.preload   = 1'b1;
                IR_WIDTH'(OP_EXTEST):     dec.extest    = 1'b1;
                IR_WIDTH'(OP_RUN_MBIST):  dec.runmbist  = 1'b1;
                IR_WIDTH'(OP_RUNSCAN):    dec.runscan   = 1'b1;
                IR_WIDTH'(OP_INTEST):     dec.intest    = 1'b1;
                IR_WIDTH'(OP_PROG_MBIST): dec.progmbist = 1'b1;
                IR_WIDTH'(OP_IDCODE):     dec.idcode    = 1'b1;
                IR_WIDTH'(OP_PROG_LBIST): dec.proglbist = 1'b1;
                IR_WIDTH'(OP_RUN_LBIST):  dec.runlbist  = 1'b1;
                default: begin
                    dec.bypass = 1'b1;
                    illegal    = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/jtag_ir_unit.sv
// JTAG instruction register: capture/shift/update path with registered one-hot instruction decode.
module jtag_ir_unit
    import jtag_pkg::*;
#(
    parameter int unsigned         IR_WIDTH = 4,
    parameter logic [IR_WIDTH-1:0] RESET_OP = '0
) (
    input  logic                tck,
    input  logic                trst_n,
    input  logic                tlr,
    input  logic                tdi,
    input  logic                capture_ir,
    input  logic                shift_ir,
    input  logic                update_ir,
    input  logic [IR_WIDTH-3:0] status_in,
    output logic                ir_tdo,
    output logic [IR_WIDTH-1:0] ir_q,
    output logic                bypass,
    output logic                sample,
    output logic                preload,
    output logic                extest,
    output logic                intest,
    output logic                runmbist,
    output logic                runscan,
    output logic                runlbist,
    output logic                progmbist,
    output logic                proglbist,
    output logic                idcode,
    output logic                illegal_op
);

    logic [IR_WIDTH-1:0] shift_reg;
    logic [IR_WIDTH-1:0] dec_op;
    ir_dec_t             dec_d;
    ir_dec_t             dec_q;
    logic                dec_illegal;
    logic                rst;

    assign rst = !trst_n || tlr;

    // One decoder serves both paths: during reset it decodes RESET_OP so the reset flags follow the parameter.
    assign dec_op = rst ? RESET_OP : shift_reg;

    jtag_ir_dec #(
        .IR_WIDTH(IR_WIDTH)
    ) u_dec (
        .op      (dec_op),
        .dec     (dec_d),
        .illegal (dec_illegal)
    );

    always_ff @(posedge tck) begin
        if (rst) begin
            shift_reg  <= RESET_OP;
            ir_q       <= RESET_OP;
            dec_q      <= dec_d;
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= 1'b0;
            if (update_ir) begin
                ir_q       <= shift_reg;
                dec_q      <= dec_d;
                illegal_op <= dec_illegal;
            end else if (capture_ir) begin
                shift_reg <= {status_in, CAPTURE_LSB};
            end else if (shift_ir) begin
                shift_reg <= {tdi, shift_reg[IR_WIDTH-1:1]};
            end
        end
    end

    assign ir_tdo    = shift_reg[0];
    assign bypass    = dec_q.bypass;
    assign sample    = dec_q.sample;
    assign preload   = dec_q.preload;
    assign extest    = dec_q.extest;
    assign intest    = dec_q.intest;
    assign runmbist  = dec_q.runmbist;
    assign runscan   = dec_q.runscan;
    assign runlbist  = dec_q.runlbist;
    assign progmbist = dec_q.progmbist;
    assign proglbist = dec_q.proglbist;
    assign idcode    = dec_q.idcode;

endmodule
